id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register feeding the combinational ALU. Captures decoded operands,
//  translates funct3/funct7/op-class into the 4-bit alu_select, selects ALU A/B sources
//  (rs1/pc/zero, rs2/imm/4) and resolves RAW hazards by forwarding from MEM and WB.
//  Sits between decode and execute; the ALU's in_a/in_b/alu_select are driven from it.
// PARAMETERS
//  XLEN      32  datapath width (ALU operands, pc, imm)
//  REG_AW    5   register address width
// PORTS
//  clk           in   1       rising-edge clock
//  rst           in   1       synchronous, active-high reset
//  flush         in   1       kill held/incoming instruction (branch redirect)
//  in_valid      in   1       decode has an instruction
//  in_ready      out  1       stage accepts this cycle
//  in_pc         in   XLEN    instruction pc
//  in_rs1_data   in   XLEN    regfile read 1
//  in_rs2_data   in   XLEN    regfile read 2
//  in_rs1_addr   in   REG_AW  source 1 index
//  in_rs2_addr   in   REG_AW  source 2 index
//  in_rd_addr    in   REG_AW  destination index
//  in_rd_we      in   1       instruction writes rd
//  in_imm        in   XLEN    sign-extended immediate
//  in_funct3     in   3       instruction funct3
//  in_funct7b5   in   1       instruction bit 30
//  in_op_class   in   3       0 R,1 I,2 LUI,3 AUIPC,4 LINK,5 BRANCH (6,7 reserved)
//  mem_we/mem_rd/mem_data  in 1/REG_AW/XLEN   EX/MEM result for forwarding
//  wb_we/wb_rd/wb_data     in 1/REG_AW/XLEN   MEM/WB result for forwarding
//  out_valid     out  1       ALU inputs valid
//  out_ready     in   1       execute consumes this cycle
//  alu_in_a      out  XLEN    ALU operand A
//  alu_in_b      out  XLEN    ALU operand B
//  alu_select    out  4       ALU op
//  out_rs2_fwd   out  XLEN    forwarded rs2 (store/branch data)
//  out_rd_addr   out  REG_AW  registered rd;  out_rd_we out 1 registered rd write enable
// BEHAVIOUR
//  - Reset: out_valid=0, all held fields 0, alu_select=ADD(0), out_rd_we=0.
//  - alu_select codes: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND.
//  - in_ready = !out_valid | out_ready. Capture when in_valid & in_ready & !flush.
//    Latency 1 cycle: accepted instr appears with out_valid=1 the next cycle.
//  - out_valid next: flush ->0; else capture ->1; else out_ready ->0; else hold.
//    flush beats a simultaneous in_valid (instruction discarded, in_ready unaffected).
//  - Decode: R: funct3 map, b5 selects SUB (000) / SRA (101). I: same map, b5 only
//    honoured for 101 (SRAI); ADDI never SUB. LUI: A=0,B=imm,ADD. AUIPC: A=pc,B=imm,ADD.
//    LINK: A=pc,B=4,ADD. BRANCH: 00x SUB, 10x SLT, 11x SLTU, 01x SUB. Reserved class:
//    ADD, out_rd_we forced 0.
//  - Forwarding (combinational on held rs1/rs2): match if addr!=0 and we and rd==addr;
//    MEM has priority over WB; otherwise held regfile value. x0 always reads 0.
//  - Stall retention: while held (out_valid & !out_ready), a WB write matching a held
//    source updates the held operand register so the value survives WB retiring.
//  - A-source/B-source selection applies after forwarding; imm/pc paths never forwarded.
//  - Reset mid-stall drops the held instruction; no output toggles besides listed resets.
// STRUCTURE
//  - Package riscv_pkg: ALU_* select constants, OPC_* op-class constants, XLEN default.
//  - Sub-module alu_ctrl (combinational): {op_class,funct3,funct7b5} -> alu_select,
//    a_sel, b_sel. Top holds registers, handshake and forwarding muxes.
// TESTING
//  - Reset: assert rst 2 cycles -> out_valid=0, alu_select=0, alu_in_a=alu_in_b=0.
//  - R SUB rs1=5(0x10),rs2=6(0x3) -> next cycle alu_in_a=0x10, alu_in_b=0x3, sel=1.
//  - I SRAI funct3=101 b5=1 imm=0x404 -> sel=7; ADDI b5=1 imm=-1 -> sel=0, B=0xFFFFFFFF.
//  - Forward: rs1=7, mem_rd=7 mem_data=0xAA, wb_rd=7 wb_data=0xBB -> alu_in_a=0xAA;
//    rs1=0 with mem_rd=0 mem_we=1 -> alu_in_a=0.
//  - Stall: out_ready=0 3 cycles, wb writes rs2=9 0x55 once -> B stays 0x55 after WB
//    clears; in_ready=0 throughout; new in_valid not captured until out_ready=1.
//  - flush with in_valid=1 -> out_valid=0 next cycle; LINK pc=0x100 -> A=0x100,B=4,sel=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the ID/EX stage: ALU select codes, op classes and
// operand source selectors, plus the funct3 -> ALU op translation.
package riscv_pkg;

   localparam int unsigned XLEN_DEF   = 32;
   localparam int unsigned REG_AW_DEF = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_sel_e;

   // Encodings 6 and 7 are reserved and intentionally absent.
   typedef enum logic [2:0] {
      OPC_R      = 3'd0,
      OPC_I      = 3'd1,
      OPC_LUI    = 3'd2,
      OPC_AUIPC  = 3'd3,
      OPC_LINK   = 3'd4,
      OPC_BRANCH = 3'd5
   } op_class_e;

   typedef enum logic [1:0] {
      A_RS1  = 2'd0,
      A_PC   = 2'd1,
      A_ZERO = 2'd2
   } a_sel_e;

   typedef enum logic [1:0] {
      B_RS2  = 2'd0,
      B_IMM  = 2'd1,
      B_FOUR = 2'd2
   } b_sel_e;

   // Base funct3 mapping shared by register and immediate arithmetic.
   function automatic alu_sel_e funct3_to_alu(input logic [2:0] f3);
      alu_sel_e sel;
      sel = ALU_ADD;
      case (f3)
         3'b000:  sel = ALU_ADD;
         3'b001:  sel = ALU_SLL;
         3'b010:  sel = ALU_SLT;
         3'b011:  sel = ALU_SLTU;
         3'b100:  sel = ALU_XOR;
         3'b101:  sel = ALU_SRL;
         3'b110:  sel = ALU_OR;
         default: sel = ALU_AND;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode -> ID/EX -> execute bundle. The master side is the surrounding
// pipeline (decode, forwarding sources, execute); the slave side is the stage.
interface id_ex_stage_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_rs1_data;
   logic [XLEN-1:0]   in_rs2_data;
   logic [REG_AW-1:0] in_rs1_addr;
   logic [REG_AW-1:0] in_rs2_addr;
   logic [REG_AW-1:0] in_rd_addr;
   logic              in_rd_we;
   logic [XLEN-1:0]   in_imm;
   logic [2:0]        in_funct3;
   logic              in_funct7b5;
   logic [2:0]        in_op_class;

   logic              mem_we;
   logic [REG_AW-1:0] mem_rd;
   logic [XLEN-1:0]   mem_data;
   logic              wb_we;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   alu_in_a;
   logic [XLEN-1:0]   alu_in_b;
   logic [3:0]        alu_select;
   logic [XLEN-1:0]   out_rs2_fwd;
   logic [REG_AW-1:0] out_rd_addr;
   logic              out_rd_we;

   modport master (
      output flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_rs1_addr,
             in_rs2_addr, in_rd_addr, in_rd_we, in_imm, in_funct3,
             in_funct7b5, in_op_class, mem_we, mem_rd, mem_data, wb_we,
             wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, alu_in_a, alu_in_b, alu_select,
             out_rs2_fwd, out_rd_addr, out_rd_we
   );

   modport slave (
      input  flush, in_valid, in_pc, in_rs1_data, in_rs2_data, in_rs1_addr,
             in_rs2_addr, in_rd_addr, in_rd_we, in_imm, in_funct3,
             in_funct7b5, in_op_class, mem_we, mem_rd, mem_data, wb_we,
             wb_rd, wb_data, out_ready,
      output in_ready, out_valid, alu_in_a, alu_in_b, alu_select,
             out_rs2_fwd, out_rd_addr, out_rd_we
   );
endinterface

// File: rtl/id_ex_stage_alu_ctrl.sv
// ALU control decode: op class + funct3 + funct7 bit 5 -> ALU op and
// operand source selection. Reserved classes decode to ADD with rd write killed.
module alu_ctrl
   import riscv_pkg::*;
(
   input  logic [2:0] op_class,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output alu_sel_e   alu_select,
   output a_sel_e     a_sel,
   output b_sel_e     b_sel,
   output logic       rd_we_allow
);

   // Per-class operation and operand source decode.
   always_comb begin
      alu_select  = ALU_ADD;
      a_sel       = A_RS1;
      b_sel       = B_RS2;
      rd_we_allow = 1'b1;
      case (op_class)
         OPC_R: begin
            alu_select = funct3_to_alu(funct3);
            if (funct7b5 && funct3 == 3'b000) alu_select = ALU_SUB;
            if (funct7b5 && funct3 == 3'b101) alu_select = ALU_SRA;
         end
         OPC_I: begin
            b_sel      = B_IMM;
            alu_select = funct3_to_alu(funct3);
            // Bit 30 is part of the immediate except for SRAI.
            if (funct7b5 && funct3 == 3'b101) alu_select = ALU_SRA;
         end
         OPC_LUI: begin
            a_sel = A_ZERO;
            b_sel = B_IMM;
         end
         OPC_AUIPC: begin
            a_sel = A_PC;
            b_sel = B_IMM;
         end
         OPC_LINK: begin
            a_sel = A_PC;
            b_sel = B_FOUR;
         end
         OPC_BRANCH: begin
            case (funct3[2:1])
               2'b10:   alu_select = ALU_SLT;
               2'b11:   alu_select = ALU_SLTU;
               default: alu_select = ALU_SUB;
            endcase
         end
         default: rd_we_allow = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: holds the decoded instruction, drives ALU operands
// with MEM/WB forwarding, and keeps held operands fresh across stalls.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEF,
   parameter int unsigned REG_AW = REG_AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   id_ex_stage_if.slave  bus
);

   logic              valid_q, valid_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
   logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]   imm_q, imm_d;
   logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
   logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
   logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
   logic              rd_we_q, rd_we_d;
   alu_sel_e          sel_q, sel_d;
   a_sel_e            a_sel_q, a_sel_d;
   b_sel_e            b_sel_q, b_sel_d;

   alu_sel_e          dec_sel;
   a_sel_e            dec_a_sel;
   b_sel_e            dec_b_sel;
   logic              dec_rd_we_allow;

   logic              in_ready;
   logic              capture;
   logic              held;
   logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
   logic [XLEN-1:0]   alu_a, alu_b;

   alu_ctrl u_alu_ctrl (
      .op_class    (bus.in_op_class),
      .funct3      (bus.in_funct3),
      .funct7b5    (bus.in_funct7b5),
      .alu_select  (dec_sel),
      .a_sel       (dec_a_sel),
      .b_sel       (dec_b_sel),
      .rd_we_allow (dec_rd_we_allow)
   );

   // Handshake, capture of a new instruction, and stall-time WB retention.
   always_comb begin
      in_ready   = !valid_q || bus.out_ready;
      capture    = bus.in_valid && in_ready && !bus.flush;
      held       = valid_q && !bus.out_ready;

      valid_d    = valid_q;
      pc_d       = pc_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      imm_d      = imm_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_addr_d  = rd_addr_q;
      rd_we_d    = rd_we_q;
      sel_d      = sel_q;
      a_sel_d    = a_sel_q;
      b_sel_d    = b_sel_q;

      if (bus.flush)          valid_d = 1'b0;
      else if (capture)       valid_d = 1'b1;
      else if (bus.out_ready) valid_d = 1'b0;

      if (capture) begin
         pc_d       = bus.in_pc;
         rs1_data_d = bus.in_rs1_data;
         rs2_data_d = bus.in_rs2_data;
         imm_d      = bus.in_imm;
         rs1_addr_d = bus.in_rs1_addr;
         rs2_addr_d = bus.in_rs2_addr;
         rd_addr_d  = bus.in_rd_addr;
         rd_we_d    = bus.in_rd_we && dec_rd_we_allow;
         sel_d      = dec_sel;
         a_sel_d    = dec_a_sel;
         b_sel_d    = dec_b_sel;
      end else if (held) begin
         // A WB result only exists for one cycle; fold it into the held copy.
         if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs1_addr_q)
            rs1_data_d = bus.wb_data;
         if (bus.wb_we && bus.wb_rd != '0 && bus.wb_rd == rs2_addr_q)
            rs2_data_d = bus.wb_data;
      end
   end

   // Stage register with synchronous reset to an idle ADD bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rd_addr_q  <= '0;
         rd_we_q    <= 1'b0;
         sel_q      <= ALU_ADD;
         a_sel_q    <= A_RS1;
         b_sel_q    <= B_RS2;
      end else begin
         valid_q    <= valid_d;
         pc_q       <= pc_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         imm_q      <= imm_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_addr_q  <= rd_addr_d;
         rd_we_q    <= rd_we_d;
         sel_q      <= sel_d;
         a_sel_q    <= a_sel_d;
         b_sel_q    <= b_sel_d;
      end
   end

   // Forwarding on held sources (MEM over WB, x0 pinned to zero), then source select.
   always_comb begin
      if (rs1_addr_q == '0)
         rs1_fwd = '0;
      else if (bus.mem_we && bus.mem_rd == rs1_addr_q)
         rs1_fwd = bus.mem_data;
      else if (bus.wb_we && bus.wb_rd == rs1_addr_q)
         rs1_fwd = bus.wb_data;
      else
         rs1_fwd = rs1_data_q;

      if (rs2_addr_q == '0)
         rs2_fwd = '0;
      else if (bus.mem_we && bus.mem_rd == rs2_addr_q)
         rs2_fwd = bus.mem_data;
      else if (bus.wb_we && bus.wb_rd == rs2_addr_q)
         rs2_fwd = bus.wb_data;
      else
         rs2_fwd = rs2_data_q;

      case (a_sel_q)
         A_PC:    alu_a = pc_q;
         A_ZERO:  alu_a = '0;
         default: alu_a = rs1_fwd;
      endcase

      case (b_sel_q)
         B_IMM:   alu_b = imm_q;
         B_FOUR:  alu_b = XLEN'(4);
         default: alu_b = rs2_fwd;
      endcase
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = valid_q;
   assign bus.alu_in_a    = alu_a;
   assign bus.alu_in_b    = alu_b;
   assign bus.alu_select  = sel_q;
   assign bus.out_rs2_fwd = rs2_fwd;
   assign bus.out_rd_addr = rd_addr_q;
   assign bus.out_rd_we   = rd_we_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode, forwarding, stall, flush.
module tb_id_ex_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_ex_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

   id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush = 0; bus.in_valid = 0; bus.in_pc = '0;
      bus.in_rs1_data = '0; bus.in_rs2_data = '0;
      bus.in_rs1_addr = '0; bus.in_rs2_addr = '0; bus.in_rd_addr = '0;
      bus.in_rd_we = 0; bus.in_imm = '0; bus.in_funct3 = '0;
      bus.in_funct7b5 = 0; bus.in_op_class = '0;
      bus.mem_we = 0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.wb_we = 0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.out_ready = 1;
   endtask

   task automatic set_instr(input logic [2:0] cls, input logic [2:0] f3,
                            input logic b5, input logic [31:0] pc,
                            input logic [4:0] r1a, input logic [31:0] r1d,
                            input logic [4:0] r2a, input logic [31:0] r2d,
                            input logic [4:0] rd, input logic [31:0] imm);
      bus.in_valid = 1; bus.in_op_class = cls; bus.in_funct3 = f3;
      bus.in_funct7b5 = b5; bus.in_pc = pc;
      bus.in_rs1_addr = r1a; bus.in_rs1_data = r1d;
      bus.in_rs2_addr = r2a; bus.in_rs2_data = r2d;
      bus.in_rd_addr = rd; bus.in_rd_we = 1; bus.in_imm = imm;
   endtask

   task automatic test_reset();
      idle_inputs();
      set_instr(3'd0, 3'd0, 1'b1, 32'h40, 5'd3, 32'h99, 5'd4, 32'h77, 5'd5, 32'h1);
      rst = 1;
      tick(); tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", bus.out_valid); end
      checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL reset_sel got %h exp 0", bus.alu_select); end
      checks++; if (bus.alu_in_a !== 32'h0) begin errors++; $display("FAIL reset_a got %h exp 0", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h0) begin errors++; $display("FAIL reset_b got %h exp 0", bus.alu_in_b); end
      checks++; if (bus.out_rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got %h exp 0", bus.out_rd_we); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h exp 1", bus.in_ready); end
      idle_inputs();
      rst = 0;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %h exp 0", bus.out_valid); end
   endtask

   task automatic test_r_sub();
      set_instr(3'd0, 3'b000, 1'b1, 32'h0, 5'd5, 32'h10, 5'd6, 32'h3, 5'd8, 32'h0);
      tick();
      bus.in_valid = 0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rsub_valid got %h exp 1", bus.out_valid); end
      checks++; if (bus.alu_in_a !== 32'h10) begin errors++; $display("FAIL rsub_a got %h exp 10", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h3) begin errors++; $display("FAIL rsub_b got %h exp 3", bus.alu_in_b); end
      checks++; if (bus.alu_select !== 4'd1) begin errors++; $display("FAIL rsub_sel got %h exp 1", bus.alu_select); end
      checks++; if (bus.out_rd_addr !== 5'd8) begin errors++; $display("FAIL rsub_rd got %h exp 8", bus.out_rd_addr); end
      checks++; if (bus.out_rd_we !== 1'b1) begin errors++; $display("FAIL rsub_rd_we got %h exp 1", bus.out_rd_we); end
      checks++; if (bus.out_rs2_fwd !== 32'h3) begin errors++; $display("FAIL rsub_rs2fwd got %h exp 3", bus.out_rs2_fwd); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rsub_drain got %h exp 0", bus.out_valid); end
   endtask

   task automatic test_i_type();
      set_instr(3'd1, 3'b101, 1'b1, 32'h0, 5'd2, 32'h80000000, 5'd0, 32'h0, 5'd3, 32'h404);
      tick();
      set_instr(3'd1, 3'b000, 1'b1, 32'h0, 5'd2, 32'h5, 5'd0, 32'h0, 5'd3, 32'hFFFFFFFF);
      checks++; if (bus.alu_select !== 4'd7) begin errors++; $display("FAIL srai_sel got %h exp 7", bus.alu_select); end
      checks++; if (bus.alu_in_b !== 32'h404) begin errors++; $display("FAIL srai_b got %h exp 404", bus.alu_in_b); end
      checks++; if (bus.alu_in_a !== 32'h80000000) begin errors++; $display("FAIL srai_a got %h exp 80000000", bus.alu_in_a); end
      tick();
      bus.in_valid = 0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %h exp 1", bus.out_valid); end
      checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL addi_sel got %h exp 0", bus.alu_select); end
      checks++; if (bus.alu_in_b !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_b got %h exp ffffffff", bus.alu_in_b); end
      tick();
   endtask

   task automatic test_decode_table();
      logic [2:0] cls_t [18] = '{3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd0,3'd1,3'd1,
                                 3'd5,3'd5,3'd5,3'd5,3'd5,3'd5,3'd5,3'd6,3'd7};
      logic [2:0] f3_t  [18] = '{3'b101,3'b101,3'b111,3'b110,3'b100,3'b011,3'b001,3'b110,3'b001,
                                 3'b000,3'b001,3'b100,3'b101,3'b110,3'b111,3'b010,3'b100,3'b101};
      logic       b5_t  [18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,
                                 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
      logic [3:0] sel_t [18] = '{4'd7,4'd6,4'd9,4'd8,4'd5,4'd4,4'd2,4'd8,4'd2,
                                 4'd1,4'd1,4'd3,4'd3,4'd4,4'd4,4'd1,4'd0,4'd0};
      logic       we_t  [18] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,
                                 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0};
      for (int i = 0; i < 18; i++) begin
         set_instr(cls_t[i], f3_t[i], b5_t[i], 32'h0, 5'd1, 32'h0, 5'd2, 32'h0, 5'd7, 32'h0);
         tick();
         checks++; if (bus.alu_select !== sel_t[i]) begin errors++; $display("FAIL decode_sel[%0d] got %h exp %h", i, bus.alu_select, sel_t[i]); end
         checks++; if (bus.out_rd_we !== we_t[i]) begin errors++; $display("FAIL decode_rd_we[%0d] got %h exp %h", i, bus.out_rd_we, we_t[i]); end
      end
      bus.in_valid = 0;
      tick();
   endtask

   task automatic test_forward();
      set_instr(3'd0, 3'b000, 1'b0, 32'h0, 5'd7, 32'h11, 5'd3, 32'h22, 5'd4, 32'h0);
      tick();
      bus.in_valid = 0;
      bus.mem_we = 1; bus.mem_rd = 5'd7; bus.mem_data = 32'hAA;
      bus.wb_we = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'hBB;
      #1;
      checks++; if (bus.alu_in_a !== 32'hAA) begin errors++; $display("FAIL fwd_mem_prio got %h exp aa", bus.alu_in_a); end
      bus.mem_we = 0;
      #1;
      checks++; if (bus.alu_in_a !== 32'hBB) begin errors++; $display("FAIL fwd_wb got %h exp bb", bus.alu_in_a); end
      bus.wb_we = 0;
      #1;
      checks++; if (bus.alu_in_a !== 32'h11) begin errors++; $display("FAIL fwd_none got %h exp 11", bus.alu_in_a); end
      bus.wb_we = 1; bus.wb_rd = 5'd3; bus.wb_data = 32'h33;
      #1;
      checks++; if (bus.alu_in_b !== 32'h33) begin errors++; $display("FAIL fwd_rs2_b got %h exp 33", bus.alu_in_b); end
      checks++; if (bus.out_rs2_fwd !== 32'h33) begin errors++; $display("FAIL fwd_rs2_out got %h exp 33", bus.out_rs2_fwd); end
      bus.wb_we = 0;
      tick();
      // x0 must never take a forwarded value.
      bus.mem_we = 1; bus.mem_rd = 5'd0; bus.mem_data = 32'hCC;
      set_instr(3'd0, 3'b000, 1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 32'h0);
      tick();
      checks++; if (bus.alu_in_a !== 32'h0) begin errors++; $display("FAIL fwd_x0_a got %h exp 0", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h0) begin errors++; $display("FAIL fwd_x0_b got %h exp 0", bus.alu_in_b); end
      // pc/imm paths ignore a matching forward.
      bus.mem_rd = 5'd7; bus.mem_data = 32'hAA;
      set_instr(3'd3, 3'b000, 1'b0, 32'h200, 5'd7, 32'h11, 5'd0, 32'h0, 5'd4, 32'h1000);
      tick();
      checks++; if (bus.alu_in_a !== 32'h200) begin errors++; $display("FAIL auipc_a got %h exp 200", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h1000) begin errors++; $display("FAIL auipc_b got %h exp 1000", bus.alu_in_b); end
      set_instr(3'd2, 3'b000, 1'b0, 32'h200, 5'd7, 32'h11, 5'd0, 32'h0, 5'd4, 32'hABCDE000);
      tick();
      bus.in_valid = 0; bus.mem_we = 0;
      checks++; if (bus.alu_in_a !== 32'h0) begin errors++; $display("FAIL lui_a got %h exp 0", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'hABCDE000) begin errors++; $display("FAIL lui_b got %h exp abcde000", bus.alu_in_b); end
      checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL lui_sel got %h exp 0", bus.alu_select); end
      tick();
   endtask

   task automatic test_stall();
      set_instr(3'd0, 3'b000, 1'b0, 32'h0, 5'd1, 32'h1, 5'd9, 32'h9, 5'd2, 32'h0);
      tick();
      bus.in_valid = 0; bus.out_ready = 0;
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0 got %h exp 0", bus.in_ready); end
      bus.wb_we = 1; bus.wb_rd = 5'd9; bus.wb_data = 32'h55;
      set_instr(3'd4, 3'b000, 1'b0, 32'h300, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0);
      #1;
      checks++; if (bus.alu_in_b !== 32'h55) begin errors++; $display("FAIL stall_b_fwd got %h exp 55", bus.alu_in_b); end
      for (int c = 0; c < 3; c++) begin
         tick();
         bus.wb_we = 0;
         #1;
         checks++; if (bus.alu_in_b !== 32'h55) begin errors++; $display("FAIL stall_b_held[%0d] got %h exp 55", c, bus.alu_in_b); end
         checks++; if (bus.alu_in_a !== 32'h1) begin errors++; $display("FAIL stall_a_held[%0d] got %h exp 1", c, bus.alu_in_a); end
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %h exp 1", c, bus.out_valid); end
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %h exp 0", c, bus.in_ready); end
      end
      bus.out_ready = 1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %h exp 1", bus.in_ready); end
      tick();
      bus.in_valid = 0;
      checks++; if (bus.alu_in_a !== 32'h300) begin errors++; $display("FAIL after_stall_a got %h exp 300", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h4) begin errors++; $display("FAIL after_stall_b got %h exp 4", bus.alu_in_b); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL after_stall_valid got %h exp 1", bus.out_valid); end
      tick();
   endtask

   task automatic test_flush();
      bus.flush = 1;
      set_instr(3'd4, 3'b000, 1'b0, 32'h500, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %h exp 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %h exp 0", bus.out_valid); end
      bus.flush = 0;
      set_instr(3'd4, 3'b000, 1'b0, 32'h100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd1, 32'h0);
      tick();
      bus.in_valid = 0; bus.out_ready = 0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL link_valid got %h exp 1", bus.out_valid); end
      checks++; if (bus.alu_in_a !== 32'h100) begin errors++; $display("FAIL link_a got %h exp 100", bus.alu_in_a); end
      checks++; if (bus.alu_in_b !== 32'h4) begin errors++; $display("FAIL link_b got %h exp 4", bus.alu_in_b); end
      checks++; if (bus.alu_select !== 4'd0) begin errors++; $display("FAIL link_sel got %h exp 0", bus.alu_select); end
      bus.flush = 1;
      tick();
      bus.flush = 0; bus.out_ready = 1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_held got %h exp 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid_stall();
      set_instr(3'd0, 3'b000, 1'b0, 32'h0, 5'd5, 32'h77, 5'd6, 32'h66, 5'd2, 32'h0);
      tick();
      bus.in_valid = 0; bus.out_ready = 0;
      tick();
      checks++; if (bus.alu_in_a !== 32'h77) begin errors++; $display("FAIL midstall_a got %h exp 77", bus.alu_in_a); end
      rst = 1;
      tick();
      rst = 0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midstall_rst_valid got %h exp 0", bus.out_valid); end
      checks++; if (bus.alu_in_a !== 32'h0) begin errors++; $display("FAIL midstall_rst_a got %h exp 0", bus.alu_in_a); end
      checks++; if (bus.out_rd_we !== 1'b0) begin errors++; $display("FAIL midstall_rst_we got %h exp 0", bus.out_rd_we); end
      bus.out_ready = 1;
   endtask

   initial begin
      test_reset();
      test_r_sub();
      test_i_type();
      test_decode_table();
      test_forward();
      test_stall();
      test_flush();
      test_reset_mid_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
